// File: rtl/fraction_reducer.sv
// Reduces an operand pair by a common divisor (normally their GCD) using one
// shared restoring shift-subtract divider, run first on a and then on b.
module fraction_reducer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] gcd,
  output logic             done,
  output logic [WIDTH-1:0] a_red,
  output logic [WIDTH-1:0] b_red,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIV_A, DIV_B, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] b_hold;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] qa;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             fits;

  // The dividend is consumed MSB-first by shifting it left each step. The
  // remainder stays below the divisor, so a WIDTH+1 bit register never overflows.
  always_comb begin
    rem_shift = {rem[WIDTH-1:0], dividend[WIDTH-1]};
    fits      = rem_shift >= {1'b0, divisor};
    rem_next  = fits ? (rem_shift - {1'b0, divisor}) : rem_shift;
    quo_next  = {quo[WIDTH-2:0], fits};
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dividend <= '0;
      b_hold   <= '0;
      divisor  <= '0;
      quo      <= '0;
      qa       <= '0;
      rem      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      a_red    <= '0;
      b_red    <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend <= a;
            b_hold   <= b;
            divisor  <= gcd;
            err      <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          rem <= '0;
          quo <= '0;
          cnt <= CNT_TOP;
          if (divisor == '0) begin
            a_red <= '0;
            b_red <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIV_A;
          end
        end
        DIV_A: begin
          rem      <= rem_next;
          quo      <= quo_next;
          dividend <= dividend << 1;
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            qa       <= quo_next;
            dividend <= b_hold;
            rem      <= '0;
            quo      <= '0;
            cnt      <= CNT_TOP;
            state    <= DIV_B;
          end
        end
        DIV_B: begin
          rem      <= rem_next;
          quo      <= quo_next;
          dividend <= dividend << 1;
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            a_red <= qa;
            b_red <= quo_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fraction_reducer.sv
// Directed bench for fraction_reducer: expected results are queued at each
// accepted start and compared, with latency, when done pulses.
module tb_fraction_reducer;

  localparam int W = 16;
  localparam int LAT_NORM = 2 * W + 1;
  localparam int LAT_ZERO = 1;

  typedef struct packed {
    logic [W-1:0] a_red;
    logic [W-1:0] b_red;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] gcd = '0;
  logic         done;
  logic [W-1:0] a_red;
  logic [W-1:0] b_red;
  logic         err;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  fraction_reducer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .gcd(gcd),
    .done(done), .a_red(a_red), .b_red(b_red), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one start pulse; returns positioned in the cycle after the start edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] gv);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; gcd = gv; start = 1'b1;
    e.err   = (gv == '0);
    e.a_red = (gv == '0) ? '0 : av / gv;
    e.b_red = (gv == '0) ? '0 : bv / gv;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, expecting it 'lat' cycles from now; then check results and pulse width.
  task automatic wait_done(input string tag, input int lat);
    int   idx = 0;
    exp_t e;
    while (done !== 1'b1 && idx < 100) begin
      @(negedge clk);
      idx++;
    end
    check({tag, "_latency"}, idx, lat);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_a_red"}, a_red, e.a_red);
      check({tag, "_b_red"}, b_red, e.b_red);
      check({tag, "_err"}, err, e.err);
    end
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_done", done, 1'b0);
    check("reset_a_red", a_red, 0);
    check("reset_b_red", b_red, 0);
    check("reset_err", err, 1'b0);
    rst_n = 1'b1;

    issue(16'd65, 16'd25, 16'd5);
    wait_done("basic", LAT_NORM);

    issue(16'd0, 16'd36, 16'd36);
    wait_done("zero_a", LAT_NORM);
    issue(16'd37, 16'd75, 16'd1);
    wait_done("gcd_one", LAT_NORM);

    issue(16'd0, 16'd0, 16'd0);
    wait_done("gcd_zero", LAT_ZERO);
    issue(16'd11, 16'd11, 16'd11);
    wait_done("after_err", LAT_NORM);

    issue(16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done("max", LAT_NORM);
    issue(16'd65534, 16'd3, 16'd2);
    wait_done("nondiv", LAT_NORM);

    // Start pulse and input changes mid-operation must be ignored.
    issue(16'd65, 16'd25, 16'd5);
    repeat (9) @(negedge clk);
    a = 16'd100; b = 16'd10; gcd = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start", LAT_NORM - 10);
    expect_no_done("single_done", 40);

    // Reset mid-operation aborts with no done.
    issue(16'd65, 16'd25, 16'd5);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_done", done, 1'b0);
    check("abort_a_red", a_red, 0);
    check("abort_b_red", b_red, 0);
    check("abort_err", err, 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("abort_no_done", 40);
    issue(16'd12, 16'd18, 16'd6);
    wait_done("restart", LAT_NORM);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fraction_reducer.md
Name: fraction_reducer

Overview:
- Downstream consumer of the GCD unit's result.
- Takes an operand pair (a, b) and the gcd the GCD unit computed for that pair. Produces the reduced pair a/gcd and b/gcd, for example to reduce a ratio to lowest terms.
- Uses a sequential restoring shift-subtract divider, shared between the two divisions, with the same start/done handshake as the GCD unit.

Parameters:
- WIDTH, 16, bit width of a, b, gcd and both quotients.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  first operand (dividend 1).
- b  input  WIDTH  second operand (dividend 2).
- gcd  input  WIDTH  divisor, normally the GCD unit's gcd output for (a, b).
- done  output  1  one-cycle pulse: results valid.
- a_red  output  WIDTH  floor(a/gcd).
- b_red  output  WIDTH  floor(b/gcd).
- err  output  1  set with done when gcd == 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - done = 0, err = 0, a_red = 0, b_red = 0.
  - Internal registers cleared.
  - Reset mid-operation aborts the operation; no done follows.
- States and transitions:
  - IDLE: on edge with start = 1, latch a, b, gcd into internal registers.
    - If latched gcd == 0, go to DONE with the error flag set.
    - Otherwise go to DIV_A with remainder = 0 and bit counter = WIDTH-1.
  - DIV_A: one quotient bit per cycle, MSB first.
    - rem' = {rem, dividend[i]}.
    - If rem' >= divisor: rem = rem' - divisor, q[i] = 1. Else rem = rem', q[i] = 0.
    - The remainder register is WIDTH+1 bits, so the shift never overflows.
    - After WIDTH iterations, store the quotient, clear the remainder, go to DIV_B.
  - DIV_B: identical procedure on b. After WIDTH iterations go to DONE.
  - DONE: done = 1 for exactly this one cycle; a_red and b_red are updated on entry to DONE. Next edge returns to IDLE.
- Latency, with start sampled at edge T0:
  - Normal case: done is high in the cycle following edge T0 + 2*WIDTH + 1 (T33 for WIDTH = 16).
  - gcd == 0 case: done is high in the cycle following edge T1.
- Outputs:
  - done is registered. a_red, b_red and err are registered and are loaded only on entry to DONE.
  - They hold their values until the next DONE or reset.
  - err is cleared on the next accepted start.
- gcd == 0: err = 1 and a_red = b_red = 0. This covers a = b = 0, where the GCD unit returns 0.
- gcd does not divide a or b: no check is made. Outputs are the truncated quotients, err = 0.
- Sequencing rules:
  - start while not in IDLE is ignored, and a, b, gcd changes mid-operation have no effect.
  - start held high continuously restarts in the cycle after DONE returns to IDLE.
  - start asserted in the same cycle as DONE is ignored; only starts sampled in IDLE are accepted.
- Arithmetic is unsigned throughout. gcd = 1 and gcd = a are not fast-pathed; latency is fixed.

Test Plan:
- a=65, b=25, gcd=5; start pulsed for 1 cycle -> done pulses once, 33 edges after the start edge; a_red=13, b_red=5, err=0; done low on the next cycle.
- a=0, b=36, gcd=36 -> a_red=0, b_red=1, err=0. Then a=37, b=75, gcd=1 -> a_red=37, b_red=75.
- a=0, b=0, gcd=0 -> done in the cycle after edge T1; err=1, a_red=b_red=0. Next start with a=11, b=11, gcd=11 -> err=0, a_red=b_red=1.
- a=65535, b=65535, gcd=65535 -> a_red=b_red=1. Also a=65534, b=3, gcd=2 (non-divisor) -> a_red=32767, b_red=1, err=0.
- Start with a=65, b=25, gcd=5; at cycle 10 apply start with a=100, b=10, gcd=10 -> ignored; results 13/5; exactly one done pulse.
- Start with a=65, b=25, gcd=5; drop rst_n at cycle 20 -> all outputs immediately 0 and no done. Restart with a=12, b=18, gcd=6 after reset -> a_red=2, b_red=3.
